// File: rtl/msx_mouse_reader_if.sv
// rtl/msx_mouse_reader_if.sv - host request/report and joystick-port lines of the MSX mouse reader
interface msx_mouse_reader_if;
  logic       start;
  logic       busy;
  logic       strobe;
  logic [5:0] pdata;
  logic [7:0] dx;
  logic [7:0] dy;
  logic [1:0] btn;
  logic       valid;

  modport master (input start, pdata, output busy, strobe, dx, dy, btn, valid);
  modport slave  (output start, pdata, input busy, strobe, dx, dy, btn, valid);
endinterface

// File: rtl/msx_mouse_reader.sv
// rtl/msx_mouse_reader.sv - host-side MSX mouse nibble reader producing signed dx/dy and buttons
module msx_mouse_reader #(
  parameter int SETTLE_CYC = 430,
  parameter int POLL_CYC   = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  msx_mouse_reader_if.master mif
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [31:0] POLL_LAST   = 32'(POLL_CYC - 1);
  localparam bit          POLL_EN     = (POLL_CYC != 0);

  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] poll_q, poll_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  nib_q [4];
  logic [3:0]  nib_d [4];
  logic [1:0]  braw_q, braw_d;
  logic        level_q, level_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  dx_q, dx_d, dy_q, dy_d;
  logic [1:0]  btn_q, btn_d;
  logic        launch;

  // Mouse reports positive = left/up; negate, and clamp -128 which has no positive twin.
  function automatic logic [7:0] to_delta(input logic [7:0] raw);
    return (raw == 8'h80) ? 8'h7F : (~raw + 8'd1);
  endfunction

  always_comb begin
    sync1_d  = mif.pdata;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    poll_d   = poll_q;
    k_d      = k_q;
    nib_d    = nib_q;
    braw_d   = braw_q;
    level_d  = level_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    dx_d     = dx_q;
    dy_d     = dy_q;
    btn_d    = btn_q;
    launch   = 1'b0;
    // The pin follows the sequencer level one cycle later, so each sample lands SETTLE_CYC after its edge.
    strobe_d = level_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        launch = !busy_q && (mif.start || (POLL_EN && (poll_q == POLL_LAST)));
        if (POLL_EN) poll_d = poll_q + 32'd1;
        if (launch) begin
          state_d = SETTLE;
          level_d = ~level_q;
          busy_d  = 1'b1;
          k_d     = 2'd0;
          cnt_d   = 16'd0;
          poll_d  = 32'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        nib_d[k_q] = sync2_q[3:0];
        if (k_q != 2'd3) begin
          k_d     = k_q + 2'd1;
          level_d = ~level_q;
          cnt_d   = 16'd0;
          state_d = SETTLE;
        end else begin
          braw_d  = sync2_q[5:4];
          state_d = DONE;
        end
      end
      DONE: begin
        dx_d    = to_delta({nib_q[0], nib_q[1]});
        dy_d    = to_delta({nib_q[2], nib_q[3]});
        btn_d   = ~braw_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sync1_q  <= 6'd0;
      sync2_q  <= 6'd0;
      cnt_q    <= 16'd0;
      poll_q   <= 32'd0;
      k_q      <= 2'd0;
      nib_q    <= '{default: 4'd0};
      braw_q   <= 2'd0;
      level_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dx_q     <= 8'd0;
      dy_q     <= 8'd0;
      btn_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      poll_q   <= poll_d;
      k_q      <= k_d;
      nib_q    <= nib_d;
      braw_q   <= braw_d;
      level_q  <= level_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      btn_q    <= btn_d;
    end
  end

  assign mif.strobe = strobe_q;
  assign mif.busy   = busy_q;
  assign mif.valid  = valid_q;
  assign mif.dx     = dx_q;
  assign mif.dy     = dy_q;
  assign mif.btn    = btn_q;
endmodule

// File: tb/tb_msx_mouse_reader.sv
// tb/tb_msx_mouse_reader.sv - scoreboard bench for msx_mouse_reader
module tb_msx_mouse_reader;
  localparam int S   = 430;
  localparam int P   = 2000;
  localparam int LAT = 5 + 4 * S;

  typedef struct {
    int         c;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
  } rep_t;
  typedef struct {
    int         at;
    logic [5:0] v;
  } drv_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  msx_mouse_reader_if mif ();
  msx_mouse_reader_if mif2 ();

  msx_mouse_reader #(.SETTLE_CYC(S)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .mif(mif));
  msx_mouse_reader #(.SETTLE_CYC(S), .POLL_CYC(P)) dut2 (.clk_sys(clk_sys), .reset_n(reset_n), .mif(mif2));

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [3:0] nib [4];
  logic [1:0] resp_btn   = 2'b11;
  logic       resp_en    = 1'b1;
  logic [5:0] man_pdata  = 6'h3F;
  logic [5:0] resp_pdata = 6'h3F;
  int         resp_idx   = 0;
  logic       resp_prev  = 1'b0;

  // Mouse model: presents nibble k after the k-th strobe edge of a read.
  always @(negedge clk_sys) begin
    if (!mif.busy) resp_idx = 0;
    else if (mif.strobe !== resp_prev) begin
      resp_pdata = {resp_btn, nib[resp_idx[1:0]]};
      resp_idx   = resp_idx + 1;
    end
    resp_prev = mif.strobe;
  end

  assign mif.pdata  = resp_en ? resp_pdata : man_pdata;
  assign mif2.pdata = 6'h3F;

  rep_t exp_q[$];
  rep_t obs_q[$];
  rep_t obs2_q[$];
  int   edge_q[$];
  int   edge2_q[$];
  drv_t sched_q[$];
  logic st_prev  = 1'b0;
  logic st2_prev = 1'b0;

  task automatic observe(input int n, input int s1, input int s2, input int p1);
    rep_t r;
    drv_t d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (mif.strobe !== st_prev) edge_q.push_back(cyc);
      if (mif2.strobe !== st2_prev) edge2_q.push_back(cyc);
      st_prev  = mif.strobe;
      st2_prev = mif2.strobe;
      if (mif.valid === 1'b1) begin
        r.c = cyc; r.dx = mif.dx; r.dy = mif.dy; r.btn = mif.btn;
        obs_q.push_back(r);
      end
      if (mif2.valid === 1'b1) begin
        r.c = cyc; r.dx = mif2.dx; r.dy = mif2.dy; r.btn = mif2.btn;
        obs2_q.push_back(r);
      end
      while (sched_q.size() > 0 && sched_q[0].at == cyc) begin
        d = sched_q.pop_front();
        man_pdata = d.v;
      end
      mif.start  = (i == s1) || (i == s2);
      mif2.start = (i == p1);
    end
  endtask

  task automatic push_exp(input int c, input logic [7:0] dx, input logic [7:0] dy, input logic [1:0] btn);
    rep_t e;
    e.c = c; e.dx = dx; e.dy = dy; e.btn = btn;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    mif.start  = 1'b0;
    mif2.start = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk_sys);
    tests++;
    if ({mif.strobe, mif.busy, mif.valid, mif.dx, mif.dy, mif.btn} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: got strobe=%b busy=%b valid=%b dx=%h dy=%h btn=%b, want all zero",
               mif.strobe, mif.busy, mif.valid, mif.dx, mif.dy, mif.btn);
    end
    tests++;
    if ({mif2.strobe, mif2.busy, mif2.valid, mif2.dx, mif2.dy, mif2.btn} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state_poll: got strobe=%b busy=%b valid=%b dx=%h dy=%h btn=%b, want all zero",
               mif2.strobe, mif2.busy, mif2.valid, mif2.dx, mif2.dy, mif2.btn);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    rep_t e, o;
    int   ev;
    nib = '{4'h0, 4'h5, 4'hF, 4'hB};
    resp_btn = 2'b11;
    edge_q.delete(); obs_q.delete();
    ev = cyc + 2;
    push_exp(ev + LAT, 8'hFB, 8'h05, 2'b00);
    observe(LAT + 40, 0, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL basic_report: no valid pulse, want one at cycle %0d", e.c);
      end else begin
        o = obs_q.pop_front();
        if ({o.c, o.dx, o.dy, o.btn} !== {e.c, e.dx, e.dy, e.btn}) begin
          fails++;
          $display("FAIL basic_report: got cyc=%0d dx=%h dy=%h btn=%b, want cyc=%0d dx=%h dy=%h btn=%b",
                   o.c, o.dx, o.dy, o.btn, e.c, e.dx, e.dy, e.btn);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL basic_extra_valid: got %0d extra pulses, want 0", obs_q.size()); end
    tests++;
    if (edge_q.size() != 4) begin fails++; $display("FAIL basic_edge_count: got %0d, want 4", edge_q.size()); end
    for (int k = 0; k < 4 && k < edge_q.size(); k++) begin
      tests++;
      if (edge_q[k] != ev + 1 + k * (S + 1)) begin
        fails++; $display("FAIL basic_edge_time k=%0d: got %0d, want %0d", k, edge_q[k], ev + 1 + k * (S + 1));
      end
    end
    tests++;
    if (mif.strobe !== 1'b0) begin fails++; $display("FAIL basic_final_strobe: got %b, want 0", mif.strobe); end
  endtask

  task automatic test_saturate();
    rep_t e, o;
    nib = '{4'h8, 4'h0, 4'h0, 4'h1};
    resp_btn = 2'b10;
    edge_q.delete(); obs_q.delete();
    push_exp(cyc + 2 + LAT, 8'h7F, 8'hFF, 2'b01);
    observe(LAT + 40, 0, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL saturate_report: no valid pulse, want one at cycle %0d", e.c);
      end else begin
        o = obs_q.pop_front();
        if ({o.c, o.dx, o.dy, o.btn} !== {e.c, e.dx, e.dy, e.btn}) begin
          fails++;
          $display("FAIL saturate_report: got cyc=%0d dx=%h dy=%h btn=%b, want cyc=%0d dx=%h dy=%h btn=%b",
                   o.c, o.dx, o.dy, o.btn, e.c, e.dx, e.dy, e.btn);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    rep_t e, o;
    nib = '{4'h3, 4'hC, 4'h7, 4'hE};
    resp_btn = 2'b01;
    edge_q.delete(); obs_q.delete();
    push_exp(cyc + 2 + LAT, 8'hC4, 8'h82, 2'b10);
    observe(LAT + 40, 0, 10, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL busy_start_report: no valid pulse, want one at cycle %0d", e.c);
      end else begin
        o = obs_q.pop_front();
        if ({o.c, o.dx, o.dy, o.btn} !== {e.c, e.dx, e.dy, e.btn}) begin
          fails++;
          $display("FAIL busy_start_report: got cyc=%0d dx=%h dy=%h btn=%b, want cyc=%0d dx=%h dy=%h btn=%b",
                   o.c, o.dx, o.dy, o.btn, e.c, e.dx, e.dy, e.btn);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL busy_start_extra_valid: got %0d extra pulses, want 0", obs_q.size()); end
    tests++;
    if (edge_q.size() != 4) begin fails++; $display("FAIL busy_start_edges: got %0d, want 4", edge_q.size()); end
  endtask

  task automatic test_reset_mid();
    rep_t e, o;
    nib = '{4'h6, 4'h6, 4'h6, 4'h6};
    resp_btn = 2'b00;
    edge_q.delete(); obs_q.delete();
    observe(2 * S + 7, 0, -1, -1);
    tests++;
    if (mif.strobe !== 1'b1 || mif.busy !== 1'b1) begin
      fails++; $display("FAIL reset_mid_pre: got strobe=%b busy=%b, want 1 1", mif.strobe, mif.busy);
    end
    reset_n = 1'b0;
    @(negedge clk_sys);
    tests++;
    if ({mif.strobe, mif.busy, mif.valid, mif.dx, mif.dy, mif.btn} !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid_state: got strobe=%b busy=%b valid=%b dx=%h dy=%h btn=%b, want all zero",
               mif.strobe, mif.busy, mif.valid, mif.dx, mif.dy, mif.btn);
    end
    reset_n  = 1'b1;
    st_prev  = mif.strobe;
    st2_prev = mif2.strobe;
    edge_q.delete(); obs_q.delete();
    observe(LAT + 40, -1, -1, -1);
    tests++;
    if (obs_q.size() != 0 || edge_q.size() != 0) begin
      fails++; $display("FAIL reset_mid_quiet: got %0d valids %0d edges, want 0 0", obs_q.size(), edge_q.size());
    end
    nib = '{4'h2, 4'h0, 4'h0, 4'h2};
    edge_q.delete(); obs_q.delete();
    push_exp(cyc + 2 + LAT, 8'hE0, 8'hFE, 2'b11);
    observe(LAT + 40, 0, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL reset_mid_rerun: no valid pulse, want one at cycle %0d", e.c);
      end else begin
        o = obs_q.pop_front();
        if ({o.c, o.dx, o.dy, o.btn} !== {e.c, e.dx, e.dy, e.btn}) begin
          fails++;
          $display("FAIL reset_mid_rerun: got cyc=%0d dx=%h dy=%h btn=%b, want cyc=%0d dx=%h dy=%h btn=%b",
                   o.c, o.dx, o.dy, o.btn, e.c, e.dx, e.dy, e.btn);
        end
      end
    end
    tests++;
    if (edge_q.size() != 4) begin fails++; $display("FAIL reset_mid_rerun_edges: got %0d, want 4", edge_q.size()); end
  endtask

  task automatic test_poll();
    int v, ev;
    obs2_q.delete(); edge2_q.delete();
    observe(3 * (P + LAT), -1, -1, -1);
    tests++;
    if (obs2_q.size() < 2) begin fails++; $display("FAIL poll_count: got %0d pulses, want at least 2", obs2_q.size()); end
    for (int i = 0; i < obs2_q.size(); i++) begin
      tests++;
      if ({obs2_q[i].dx, obs2_q[i].dy, obs2_q[i].btn} !== {8'h01, 8'h01, 2'b00}) begin
        fails++; $display("FAIL poll_value %0d: got dx=%h dy=%h btn=%b, want 01 01 00",
                          i, obs2_q[i].dx, obs2_q[i].dy, obs2_q[i].btn);
      end
      if (i > 0) begin
        tests++;
        if (obs2_q[i].c - obs2_q[i-1].c != P + LAT) begin
          fails++; $display("FAIL poll_spacing %0d: got %0d, want %0d", i, obs2_q[i].c - obs2_q[i-1].c, P + LAT);
        end
      end
    end
    obs2_q.delete();
    for (int w = 0; w < P + LAT + 10 && obs2_q.size() == 0; w++) observe(1, -1, -1, -1);
    tests++;
    if (obs2_q.size() == 0) begin fails++; $display("FAIL poll_sync: got no pulse within budget, want one"); end
    v = cyc;
    obs2_q.delete(); edge2_q.delete();
    observe(P + LAT + 50, -1, -1, P - 2);
    tests++;
    if (obs2_q.size() != 1 || edge2_q.size() != 4) begin
      fails++; $display("FAIL poll_coincide: got %0d pulses %0d edges, want 1 4", obs2_q.size(), edge2_q.size());
    end else begin
      tests++;
      if (obs2_q[0].c != v + P + LAT) begin
        fails++; $display("FAIL poll_coincide_time: got %0d, want %0d", obs2_q[0].c, v + P + LAT);
      end
    end
    ev = cyc + 452;
    obs2_q.delete();
    observe(452 + 2 * LAT + P + 50, -1, -1, 450);
    tests++;
    if (obs2_q.size() != 2) begin
      fails++; $display("FAIL poll_clear_count: got %0d pulses, want 2", obs2_q.size());
    end else begin
      tests++;
      if (obs2_q[0].c != ev + LAT || obs2_q[1].c != ev + 2 * LAT + P) begin
        fails++; $display("FAIL poll_clear_time: got %0d %0d, want %0d %0d",
                          obs2_q[0].c, obs2_q[1].c, ev + LAT, ev + 2 * LAT + P);
      end
    end
  endtask

  task automatic test_sync();
    rep_t e, o;
    drv_t d;
    int   ev, tk;
    logic [3:0] old_n [4];
    logic [3:0] new_n [4];
    old_n = '{4'h1, 4'h2, 4'h3, 4'h4};
    new_n = '{4'h9, 4'hA, 4'hB, 4'hC};
    resp_en = 1'b0;
    for (int run = 0; run < 2; run++) begin
      edge_q.delete(); obs_q.delete(); sched_q.delete();
      ev = cyc + 2;
      for (int k = 0; k < 4; k++) begin
        tk = ev + 1 + S + k * (S + 1);
        d.at = tk - 10;                  d.v = {2'b11, old_n[k]}; sched_q.push_back(d);
        d.at = tk - ((run == 0) ? 2 : 4); d.v = {2'b11, new_n[k]}; sched_q.push_back(d);
      end
      if (run == 0) push_exp(ev + LAT, 8'hEE, 8'hCC, 2'b00);
      else          push_exp(ev + LAT, 8'h66, 8'h44, 2'b00);
      observe(LAT + 40, 0, -1, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (obs_q.size() == 0) begin
          fails++; $display("FAIL sync_run%0d: no valid pulse, want one at cycle %0d", run, e.c);
        end else begin
          o = obs_q.pop_front();
          if ({o.c, o.dx, o.dy, o.btn} !== {e.c, e.dx, e.dy, e.btn}) begin
            fails++;
            $display("FAIL sync_run%0d: got cyc=%0d dx=%h dy=%h btn=%b, want cyc=%0d dx=%h dy=%h btn=%b",
                     run, o.c, o.dx, o.dy, o.btn, e.c, e.dx, e.dy, e.btn);
          end
        end
      end
    end
    resp_en = 1'b1;
  endtask

  initial begin
    nib = '{4'hF, 4'hF, 4'hF, 4'hF};
    mif.start  = 1'b0;
    mif2.start = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_busy_start();
    test_reset_mid();
    test_poll();
    test_sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
